// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, single-slave round-robin arbiter for the 64-bit
// system bus. Sits in front of the address decoder (Rom/Ram/Stk/Art/Key).
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   mX_req/addr/wdata/   master X request; req is held until mX_ack
//     we/re
//   mX_gnt               master X owns the bus (state == OWNx)
//   mX_ack               one-cycle completion pulse
//   mX_rdata             read data captured at completion, held otherwise
//   bus_*                slave side; driven only by the current owner, else 0
//   bus_ready            slave completes the current access this cycle
//   bus_err              one-cycle pulse on watchdog abort
//
// Optional feature: define BUS_TIMEOUT_EN to enable the ownership watchdog
// (TIMEOUT_CYCLES owned cycles without bus_ready -> ack + bus_err, rdata all
// ones). Without it the owner waits indefinitely and bus_err is 0.
module bus_arbiter #(
  parameter int AW             = 64,
  parameter int DW             = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  input  logic          m0_re,
  output logic          m0_gnt,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  input  logic          m1_re,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] bus_address,
  output logic [DW-1:0] bus_write_data,
  output logic          bus_write_enable,
  output logic          bus_read_enable,
  input  logic [DW-1:0] bus_read_data,
  input  logic          bus_ready,
  output logic          bus_err
);

  typedef struct packed {
    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic          re;
  } mreq_t;

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t           state, state_nxt;
  logic             last, last_nxt;   // master that completed most recently
  mreq_t [1:0]      mst;
  mreq_t            cur;              // request of the current owner
  logic             owned, own;
  logic             done, abort, tmo, rd;
  logic [1:0]       ack_q;
  logic [1:0][DW-1:0] rdata_q;
  logic             err_q;

  assign mst[0] = {m0_req, m0_addr, m0_wdata, m0_we, m0_re};
  assign mst[1] = {m1_req, m1_addr, m1_wdata, m1_we, m1_re};

  assign owned = (state == OWN0) || (state == OWN1);
  assign own   = (state == OWN1);
  assign cur   = mst[own];

  // Write wins when both enables are set.
  assign rd    = cur.re & ~cur.we;
  // Dropping req takes precedence: a released master never gets an ack.
  assign abort = owned && !cur.req;
  assign done  = owned && cur.req && bus_ready && (cur.we || cur.re);

`ifdef BUS_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] tcnt;

  // Held at zero outside ownership, so it is clear on every entry to OWNx.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          tcnt <= '0;
    else if (!owned)     tcnt <= '0;
    else if (!bus_ready) tcnt <= tcnt + 1'b1;
  end

  assign tmo = owned && cur.req && !bus_ready && (tcnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        // On a tie the master that did not finish last wins.
        if (mst[0].req && (!mst[1].req || last)) state_nxt = OWN0;
        else if (mst[1].req)                      state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (done || tmo) begin
          state_nxt = IDLE;
          last_nxt  = own;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      ack_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      ack_q <= '0;
      err_q <= 1'b0;
      if (done || tmo)  ack_q[own]   <= 1'b1;
      if (done && rd)   rdata_q[own] <= bus_read_data;
      if (tmo) begin
        rdata_q[own] <= '1;
        err_q        <= 1'b1;
      end
    end
  end

  // Slave side is a pure function of the owner, so a reset drops the
  // enables in the same instant.
  always_comb begin
    bus_address      = '0;
    bus_write_data   = '0;
    bus_write_enable = 1'b0;
    bus_read_enable  = 1'b0;
    if (owned) begin
      bus_address      = cur.addr;
      bus_write_data   = cur.wdata;
      bus_write_enable = cur.we;
      bus_read_enable  = rd;
    end
  end

  assign m0_gnt   = (state == OWN0);
  assign m1_gnt   = (state == OWN1);
  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];
  assign bus_err  = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized two-master traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_bus_arbiter;
  localparam int TO = 16;

  logic        clk, reset;
  logic [1:0]  mreq, mwe, mre;
  logic [63:0] maddr [2];
  logic [63:0] mwd [2];
  logic        m0_gnt, m1_gnt, m0_ack, m1_ack, bus_err;
  logic [63:0] m0_rdata, m1_rdata;
  logic [63:0] bus_address, bus_write_data, bus_read_data;
  logic        bus_write_enable, bus_read_enable, bus_ready;

  bus_arbiter #(.AW(64), .DW(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(mreq[0]), .m0_addr(maddr[0]), .m0_wdata(mwd[0]), .m0_we(mwe[0]), .m0_re(mre[0]),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(mreq[1]), .m1_addr(maddr[1]), .m1_wdata(mwd[1]), .m1_we(mwe[1]), .m1_re(mre[1]),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_write_enable(bus_write_enable), .bus_read_enable(bus_read_enable),
    .bus_read_data(bus_read_data), .bus_ready(bus_ready), .bus_err(bus_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 20) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- reference model: owner (-1 = nobody), last finisher, outputs ----
  int          owner, mlast, tcount, cyc;
  bit          m_ack [2];
  bit          m_err;
  logic [63:0] m_rdata [2];

  task automatic model_reset();
    owner = -1; mlast = 1; tcount = 0;
    m_ack[0] = 0; m_ack[1] = 0; m_err = 0;
    m_rdata[0] = '0; m_rdata[1] = '0;
  endtask

  task automatic model_step();
    int x;
    m_ack[0] = 0; m_ack[1] = 0; m_err = 0;
    cyc++;
    if (owner < 0) begin
      tcount = 0;
      if (mreq[0] && mreq[1]) owner = 1 - mlast;
      else if (mreq[0])       owner = 0;
      else if (mreq[1])       owner = 1;
    end else begin
      x = owner;
      if (!mreq[x]) owner = -1;
      else if (bus_ready && (mwe[x] || mre[x])) begin
        m_ack[x] = 1;
        if (!mwe[x]) m_rdata[x] = bus_read_data;
        mlast = x; owner = -1;
      end
`ifdef BUS_TIMEOUT_EN
      else if (!bus_ready && tcount == TO - 1) begin
        m_ack[x] = 1; m_err = 1; m_rdata[x] = '1;
        mlast = x; owner = -1;
      end
      else if (!bus_ready) tcount++;
`endif
    end
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else        model_step();
    end
  end

  // ---- per-cycle compare against the model ----
  initial begin
    logic [63:0] ea, ew;
    bit ewe, ere;
    forever begin
      @(negedge clk);
      ea = '0; ew = '0; ewe = 0; ere = 0;
      if (owner >= 0) begin
        ea = maddr[owner]; ew = mwd[owner];
        ewe = mwe[owner]; ere = mre[owner] & ~mwe[owner];
      end
      chk("m0_gnt", m0_gnt, owner == 0);
      chk("m1_gnt", m1_gnt, owner == 1);
      chk("m0_ack", m0_ack, m_ack[0]);
      chk("m1_ack", m1_ack, m_ack[1]);
      chk("m0_rdata", m0_rdata, m_rdata[0]);
      chk("m1_rdata", m1_rdata, m_rdata[1]);
      chk("bus_address", bus_address, ea);
      chk("bus_write_data", bus_write_data, ew);
      chk("bus_write_enable", bus_write_enable, ewe);
      chk("bus_read_enable", bus_read_enable, ere);
      chk("bus_err", bus_err, m_err);
    end
  end

  // ---- stimulus helpers ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_m(int i);
    mreq[i] = 0; mwe[i] = 0; mre[i] = 0;
  endtask

  task automatic new_req(int i);
    int k;
    k = $urandom_range(9, 0);
    mreq[i] = 1;
    maddr[i] = {$urandom, $urandom};
    mwd[i] = {$urandom, $urandom};
    mwe[i] = (k <= 3) || (k == 8);
    mre[i] = (k >= 4 && k <= 8);
  endtask

  task automatic drive_master(int i);
    if (mreq[i] && m_ack[i]) begin
      if ($urandom_range(3, 0) != 0) new_req(i);
      else idle_m(i);
    end else if (mreq[i] && $urandom_range(39, 0) == 0) idle_m(i);
    else if (!mreq[i] && $urandom_range(2, 0) == 0) new_req(i);
  endtask

  // ---- main sequence ----
  initial begin
    int nacks, n0, nalt, ngap, owned, got;
    int who [20];
    int acyc [20];
    logic [63:0] ones;

    reset = 0; mreq = 0; mwe = 0; mre = 0;
    maddr[0] = '0; maddr[1] = '0; mwd[0] = '0; mwd[1] = '0;
    bus_read_data = '0; bus_ready = 0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_ctrl", {m0_gnt, m1_gnt, m0_ack, m1_ack, bus_err, bus_write_enable, bus_read_enable}, 0);
    chk("rst_data", m0_rdata | m1_rdata | bus_address | bus_write_data, 0);
    tick(); reset = 1;

    // T1: single m0 write, ready on the 2nd owned cycle
    tick(); mreq[0] = 1; maddr[0] = 64'h1000; mwd[0] = 64'h41; mwe[0] = 1;
    #3 chk("t1_gnt_pre", m0_gnt, 0);
    tick();
    #3 chk("t1_gnt", m0_gnt, 1);
    chk("t1_we_c1", bus_write_enable, 1);
    chk("t1_addr_c1", bus_address, 64'h1000);
    tick(); bus_ready = 1;
    #3 chk("t1_we_c2", bus_write_enable, 1);
    chk("t1_addr_c2", bus_address, 64'h1000);
    tick(); bus_ready = 0; idle_m(0);
    #3 chk("t1_ack", m0_ack, 1);
    chk("t1_bus_idle", bus_write_enable, 0);
    tick();
    #3 chk("t1_ack_single", m0_ack, 0);

    // T2: both masters hold requests, slave always ready
    mreq = 2'b11; mwe = 2'b11; maddr[0] = 64'h2000; maddr[1] = 64'h3000; bus_ready = 1;
    nacks = 0;
    for (int c = 0; c < 60 && nacks < 20; c++) begin
      tick();
      if (m_ack[0]) maddr[0] = maddr[0] + 8;
      if (m_ack[1]) maddr[1] = maddr[1] + 8;
      #3;
      if (m0_ack || m1_ack) begin
        who[nacks] = m1_ack ? 1 : 0;
        acyc[nacks] = cyc;
        nacks++;
      end
    end
    mreq = 0; mwe = 0; bus_ready = 0;
    n0 = 0; nalt = 0; ngap = 0;
    for (int i = 0; i < nacks; i++) begin
      if (who[i] == 0) n0++;
      if (i > 0 && who[i] != who[i-1]) nalt++;
      if (i > 0 && acyc[i] - acyc[i-1] == 2) ngap++;
    end
    chk("t2_acks", nacks, 20);
    chk("t2_first_m1", who[0], 1);
    chk("t2_alternate", nalt, 19);
    chk("t2_spacing", ngap, 19);
    chk("t2_m0_share", n0, 10);
    tick(); tick();

    // T3: m1 read, then a write+read request that must not read
    mreq[1] = 1; maddr[1] = 64'h8000_0010; mre[1] = 1; mwe[1] = 0; bus_read_data = 64'h5A;
    tick();
    #3 chk("t3_gnt", m1_gnt, 1);
    chk("t3_re", bus_read_enable, 1);
    bus_ready = 1;
    tick(); bus_ready = 0; idle_m(1); bus_read_data = 64'h33;
    #3 chk("t3_ack", m1_ack, 1);
    chk("t3_rdata", m1_rdata, 64'h5A);
    tick();
    #3 chk("t3_rdata_hold", m1_rdata, 64'h5A);
    mreq[1] = 1; mwe[1] = 1; mre[1] = 1; mwd[1] = 64'h99;
    tick();
    #3 chk("t3_re_blocked", bus_read_enable, 0);
    chk("t3_we", bus_write_enable, 1);
    bus_ready = 1;
    tick(); bus_ready = 0; idle_m(1);
    #3 chk("t3_wr_ack", m1_ack, 1);
    chk("t3_wr_keeps_rdata", m1_rdata, 64'h5A);

    // T4: m0 abandons its grant, waiting m1 gets the bus next
    tick(); mreq[0] = 1; mwe[0] = 1; maddr[0] = 64'h4000;
    tick(); mreq[1] = 1; mwe[1] = 1; maddr[1] = 64'h5000;
    #3 chk("t4_gnt0", m0_gnt, 1);
    tick(); idle_m(0);
    tick();
    #3 chk("t4_abort_gnt0", m0_gnt, 0);
    chk("t4_abort_noack", m0_ack, 0);
    chk("t4_gnt1_not_yet", m1_gnt, 0);
    tick();
    #3 chk("t4_gnt1", m1_gnt, 1);
    chk("t4_noack0", m0_ack, 0);
    bus_ready = 1;
    tick(); bus_ready = 0; idle_m(1);
    #3 chk("t4_ack1", m1_ack, 1);

    // T5: reset while m1 owns the bus
    tick(); mreq[1] = 1; mre[1] = 1; maddr[1] = 64'h6000;
    tick();
    #3 chk("t5_gnt1", m1_gnt, 1);
    reset = 0;
    #1 chk("t5_rst_ctrl", {m0_gnt, m1_gnt, m0_ack, m1_ack, bus_err, bus_write_enable, bus_read_enable}, 0);
    chk("t5_rst_addr", bus_address, 0);
    chk("t5_rst_rdata", m1_rdata, 0);
    tick(); mreq[0] = 1; mre[0] = 1; maddr[0] = 64'h7000; reset = 1;
    tick();
    #3 chk("t5_tie_m0", m0_gnt, 1);
    chk("t5_tie_not_m1", m1_gnt, 0);
    idle_m(0); idle_m(1);
    tick(); tick();

    // T6: slave never ready
    mreq[0] = 1; mre[0] = 1; maddr[0] = 64'h8000;
    owned = 0; got = 0;
    for (int c = 0; c < 120 && got == 0; c++) begin
      tick();
      #3;
      if (m0_ack) got = 1;
      else if (m0_gnt) owned++;
      if (got == 1) begin
        ones = '1;
`ifdef BUS_TIMEOUT_EN
        chk("t6_rdata_ones", m0_rdata, ones);
        chk("t6_err", bus_err, 1);
`endif
      end
    end
    idle_m(0);
`ifdef BUS_TIMEOUT_EN
    chk("t6_timeout_ack", got, 1);
    chk("t6_owned_cycles", owned, TO);
`else
    chk("t6_no_ack", got, 0);
    chk("t6_owned_cycles", owned, 120);
`endif
    tick(); tick();

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      tick();
      drive_master(0);
      drive_master(1);
      bus_ready = ($urandom_range(1, 0) == 1);
      bus_read_data = {$urandom, $urandom};
    end
    idle_m(0); idle_m(1); bus_ready = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
